// File: rtl/hs32_mem_arb_pkg.sv
// rtl/hs32_mem_arb_pkg.sv - shared states, defaults and helpers for the hs32 memory arbiter
package hs32_mem_arb_pkg;

  localparam int HS32_AW_DEF  = 32;
  localparam int HS32_DW_DEF  = 32;
  localparam int HS32_MAX_NCH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_t;

  // Index of the set bit of a one-hot vector; 0 when no bit is set.
  function automatic logic [2:0] oh_to_idx(input logic [HS32_MAX_NCH-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int k = 0; k < HS32_MAX_NCH; k++) begin
      if (oh[k]) idx = 3'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/hs32_rr_pick.sv
// rtl/hs32_rr_pick.sv - combinational winner pick, round-robin after a pointer or fixed lowest-index
module hs32_rr_pick
  import hs32_mem_arb_pkg::*;
#(
  parameter int NCH = 2,
  parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  input  logic           rr_mode,
  output logic [NCH-1:0] gnt,
  output logic [IW-1:0]  idx,
  output logic           any
);

  logic [HS32_MAX_NCH-1:0] gnt_pad;

  // Walk the channels in priority order and keep only the first requester.
  // Round-robin starts just after the pointer; fixed mode starts at channel 0.
  always_comb begin
    logic found;
    int   k;
    gnt   = '0;
    found = 1'b0;
    k     = 0;
    for (int off = 1; off <= NCH; off++) begin
      if (rr_mode) k = (int'(ptr) + off) % NCH;
      else         k = off - 1;
      if (!found && req[k]) begin
        gnt[k] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  // Widen the grant so the package decoder can serve every channel count.
  always_comb begin
    gnt_pad          = '0;
    gnt_pad[NCH-1:0] = gnt;
  end

  assign idx = IW'(oh_to_idx(gnt_pad));
  assign any = |req;

endmodule

// File: rtl/hs32_mem_arb.sv
// rtl/hs32_mem_arb.sv - N-channel memory arbiter; optional bus timeout under HS32_MEM_ARB_TIMEOUT_EN
module hs32_mem_arb
  import hs32_mem_arb_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int AW      = HS32_AW_DEF,
  parameter int DW      = HS32_DW_DEF,
  parameter int RR      = 1,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              reset,
  output logic [AW-1:0]     addr,
  output logic              rw,
  input  logic [DW-1:0]     din,
  output logic [DW-1:0]     dout,
  output logic              valid,
  input  logic              ready,
  input  logic [NCH-1:0]    req_i,
  input  logic [NCH-1:0]    rw_i,
  input  logic [NCH*AW-1:0] addr_i,
  input  logic [NCH*DW-1:0] dtw_i,
  output logic [DW-1:0]     dtr_o,
  output logic [NCH-1:0]    rdy_o,
  output logic [NCH-1:0]    err_o,
  output logic [NCH-1:0]    gnt_o
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  arb_state_t     state, state_nx;
  logic [IW-1:0]  ptr;
  logic [NCH-1:0] pick_gnt;
  logic [IW-1:0]  pick_idx;
  logic           pick_any;
  logic           grant_ld;
  logic           done_ld;
  logic           tmo_hit;

  hs32_rr_pick #(
    .NCH (NCH),
    .IW  (IW)
  ) u_pick (
    .req     (req_i),
    .ptr     (ptr),
    .rr_mode (RR != 0),
    .gnt     (pick_gnt),
    .idx     (pick_idx),
    .any     (pick_any)
  );

`ifdef HS32_MEM_ARB_TIMEOUT_EN
  localparam int            TW       = (TIMEOUT < 256) ? 8 : 16;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tmo_cnt;

  // Count BUSY cycles spent without ready; restarts for every new grant.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (state != ST_BUSY) begin
      tmo_cnt <= '0;
    end else if (!ready) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // The limit is hit on the TIMEOUT-th BUSY cycle; a late ready still wins.
  assign tmo_hit = (state == ST_BUSY) && !ready && (tmo_cnt == TMO_LAST);

  // Error flag mirrors the completion pulse when the transfer was abandoned.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      err_o <= '0;
    end else if (done_ld && tmo_hit) begin
      err_o <= gnt_o;
    end else begin
      err_o <= '0;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;

  assign tmo_hit = 1'b0;
  assign err_o   = '0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next state and the load strobes for the registered bus side.
  always_comb begin
    state_nx = state;
    grant_ld = 1'b0;
    done_ld  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          grant_ld = 1'b1;
          state_nx = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if ((valid && ready) || tmo_hit) begin
          done_ld  = 1'b1;
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Registered bus outputs, grant, completion pulse, read capture and pointer.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      addr  <= '0;
      rw    <= 1'b0;
      dout  <= '0;
      valid <= 1'b0;
      dtr_o <= '0;
      rdy_o <= '0;
      gnt_o <= '0;
      ptr   <= IW'(NCH - 1);
    end else begin
      rdy_o <= '0;
      if (grant_ld) begin
        gnt_o <= pick_gnt;
        addr  <= addr_i[int'(pick_idx)*AW +: AW];
        rw    <= rw_i[pick_idx];
        dout  <= dtw_i[int'(pick_idx)*DW +: DW];
        valid <= 1'b1;
        ptr   <= pick_idx;
      end
      if (done_ld) begin
        valid <= 1'b0;
        gnt_o <= '0;
        rdy_o <= gnt_o;
        dtr_o <= tmo_hit ? '0 : din;
      end
    end
  end

endmodule
